uart_tx_framer: RTL and testbench

//  Response path of the UART/ALU link. Queues ALU results and serialises each one into a
//  3-byte response frame for the UART_TX module: header, result, checksum.

---
 rtl/uart_tx_framer_pkg.sv | 31 +++
 rtl/uart_tx_framer_sync_fifo.sv | 73 +++++++
 rtl/uart_tx_framer.sv | 128 ++++++++++++
 tb/tb_uart_tx_framer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_framer_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_framer_pkg
//   Shared protocol definitions for the UART/ALU link:
//   - frame type codes carried in the low bits of every header byte
//   - framer FSM state encodings (also exported on the framer debug port)
//   - header construction helper for the default 8-bit byte / 6-bit type code
// ----------------------------------------------------------------------------
package uart_tx_framer_pkg;

  // Frame type codes (low NB_TYPE bits of the header byte)
  localparam logic [5:0] TYPE_DATOA  = 6'b001000;
  localparam logic [5:0] TYPE_DATOB  = 6'b010000;
  localparam logic [5:0] TYPE_OP     = 6'b100000;
  localparam logic [5:0] TYPE_RESULT = 6'b000100;

  // Framer FSM state encodings
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HDR      = 3'd1;
  localparam logic [2:0] ST_WAIT_HDR = 3'd2;
  localparam logic [2:0] ST_DAT      = 3'd3;
  localparam logic [2:0] ST_WAIT_DAT = 3'd4;
  localparam logic [2:0] ST_CHK      = 3'd5;
  localparam logic [2:0] ST_WAIT_CHK = 3'd6;

  // Header byte for the default 8-bit byte / 6-bit type layout:
  // upper bits zero, type code in the low bits.
  function automatic logic [7:0] make_hdr8(input logic [5:0] i_type);
    return {2'b00, i_type};
  endfunction

endpackage

// File: rtl/uart_tx_framer_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO holding ALU results waiting to be framed.
//   Ports:
//     clk      in   system clock
//     i_rst    in   synchronous reset, active high (empties the queue)
//     i_push   in   write request; accepted when not full, or when full and a
//                   pop is accepted in the same cycle
//     i_din    in   write data
//     i_pop    in   read request; accepted when not empty
//     o_dout   out  head-of-queue data (valid while o_empty = 0)
//     o_full   out  queue holds FIFO_DEPTH entries (combinational from count)
//     o_empty  out  queue holds no entries
//   FIFO_DEPTH must be a power of 2 (>= 2) so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int NB_DATA    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [NB_DATA-1:0] i_din,
  input  logic               i_pop,
  output logic [NB_DATA-1:0] o_dout,
  output logic               o_full,
  output logic               o_empty
);

  localparam int NB_PTR = $clog2(FIFO_DEPTH);
  // One extra bit so that a full queue and an empty queue have distinct counts
  localparam int NB_CNT = NB_PTR + 1;

  logic [NB_DATA-1:0] r_mem [FIFO_DEPTH];
  logic [NB_PTR-1:0]  r_wr_ptr;
  logic [NB_PTR-1:0]  r_rd_ptr;
  logic [NB_CNT-1:0]  r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_full    = (r_count == NB_CNT'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];

  assign w_pop_ok  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full queue can still take a write
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are NB_PTR bits wide, so incrementing wraps modulo FIFO_DEPTH
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// ----------------------------------------------------------------------------
// uart_tx_framer
//   Response path of the UART/ALU link. ALU results are queued and each one is
//   sent to UART_TX as a 3-byte frame: HDR, DAT (= result), CHK (= HDR ^ DAT).
//   Handshake: the framer raises o_tx_start for exactly one cycle with o_data
//   valid; o_data then stays constant until UART_TX answers with a one-cycle
//   i_txDone. Only then may the next o_tx_start be issued.
//   Ports:
//     clk          in   system clock
//     i_rst        in   synchronous reset, active high; aborts any frame
//     i_valid      in   ALU result strobe
//     i_result     in   ALU result, sampled with i_valid
//     i_txDone     in   UART_TX byte-done strobe
//     o_tx_start   out  UART_TX start strobe (single cycle)
//     o_data       out  byte to transmit, held while the byte is in flight
//     o_busy       out  frame in progress or results still queued
//     o_full       out  result queue full
//     o_overflow   out  sticky: a result was dropped on a full queue
//     o_dbg_state  out  current FSM state (uart_tx_framer_pkg ST_* encoding)
// ----------------------------------------------------------------------------
module uart_tx_framer
  import uart_tx_framer_pkg::*;
#(
  parameter int                NB_DATA    = 8,
  parameter int                NB_TYPE    = 6,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [NB_TYPE-1:0] RESP_TYPE = TYPE_RESULT
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_result,
  input  logic               i_txDone,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_busy,
  output logic               o_full,
  output logic               o_overflow,
  output logic [2:0]         o_dbg_state
);

  localparam logic [NB_DATA-1:0] HDR_BYTE = {{(NB_DATA-NB_TYPE){1'b0}}, RESP_TYPE};

  logic [2:0]         r_state;
  logic [NB_DATA-1:0] r_frame;
  logic [NB_DATA-1:0] r_data;
  logic               r_start;
  logic               r_overflow;

  logic [NB_DATA-1:0] w_fifo_dout;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_pop;
  logic               w_drop;

  sync_fifo #(
    .NB_DATA    (NB_DATA),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_push  (i_valid),
    .i_din   (i_result),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_pop  = (r_state == ST_IDLE) && !w_fifo_empty;
  assign w_drop = i_valid && w_fifo_full && !w_pop;

  // The byte and its start strobe are registered on the transition INTO
  // HDR/DAT/CHK, so o_tx_start is high for exactly the one cycle spent in
  // those states. This gives the two-cycle i_valid -> first start latency.
  // HDR/DAT/CHK always last one cycle, so i_txDone there has no effect.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_frame    <= '0;
      r_data     <= '0;
      r_start    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_drop) r_overflow <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_frame <= w_fifo_dout;
            r_data  <= HDR_BYTE;
            r_start <= 1'b1;
            r_state <= ST_HDR;
          end
        end
        ST_HDR:  r_state <= ST_WAIT_HDR;
        ST_WAIT_HDR: begin
          if (i_txDone) begin
            r_data  <= r_frame;
            r_start <= 1'b1;
            r_state <= ST_DAT;
          end
        end
        ST_DAT:  r_state <= ST_WAIT_DAT;
        ST_WAIT_DAT: begin
          if (i_txDone) begin
            r_data  <= HDR_BYTE ^ r_frame;
            r_start <= 1'b1;
            r_state <= ST_CHK;
          end
        end
        ST_CHK:  r_state <= ST_WAIT_CHK;
        ST_WAIT_CHK: begin
          if (i_txDone) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_tx_start  = r_start;
  assign o_data      = r_data;
  assign o_busy      = (r_state != ST_IDLE) || !w_fifo_empty;
  assign o_full      = w_fifo_full;
  assign o_overflow  = r_overflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_framer.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_framer
//   Stimulus issues ALU results; each accepted result pushes its three
//   expected bytes into exp_q. A monitor pops exp_q on every o_tx_start.
//   A UART_TX responder answers every start with i_txDone after done_delay
//   cycles (or holds it back while hold_done is set).
// ----------------------------------------------------------------------------
module tb_uart_tx_framer;
  import uart_tx_framer_pkg::*;

  localparam logic [7:0] M_HDR = 8'h04;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic [7:0] i_result;
  logic       i_txDone;
  logic       o_tx_start;
  logic [7:0] o_data;
  logic       o_busy;
  logic       o_full;
  logic       o_overflow;
  logic [2:0] o_dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_framer dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_result    (i_result),
    .i_txDone    (i_txDone),
    .o_tx_start  (o_tx_start),
    .o_data      (o_data),
    .o_busy      (o_busy),
    .o_full      (o_full),
    .o_overflow  (o_overflow),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int pending  = 0;      // accepted results whose header has not been seen yet
  int byte_idx = 0;      // bytes seen since the last reset
  bit hold_done = 1'b0;
  int done_delay = 10;
  int force_done_cyc = -1;
  bit inflight = 1'b0;
  int last_done_cyc = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  // Reference model: a result r becomes the byte sequence HDR, r, HDR^r
  function automatic void push_frame(input logic [7:0] r);
    exp_q.push_back(M_HDR);
    exp_q.push_back(r);
    exp_q.push_back(M_HDR ^ r);
    pending++;
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input logic [7:0] r, input bit accepted);
    i_valid  = 1'b1;
    i_result = r;
    if (accepted) push_frame(r);
    @(negedge clk);
    i_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input bit check_gap);
    int k;
    k = 0;
    while (!(o_busy === 1'b0 && exp_q.size() == 0 && !inflight) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_idle_reached"}, 32'(k < 3000), 1);
    if (check_gap) check({name, "_busy_drop_after_done"}, cyc - last_done_cyc, 1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (o_tx_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_start: got byte 0x%0h expected no start (cycle %0d)", o_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", o_data, e);
          if (byte_idx % 3 == 0) begin
            if (pending > 0) pending--;
            if (byte_idx > 0) check("frame_spacing", 32'((cyc - last_done_cyc) >= 2), 1);
          end
          byte_idx++;
        end
      end
    end
  end

  // ---------------- UART_TX responder ----------------
  initial begin
    int cnt;
    logic [7:0] start_byte;
    cnt = 0;
    start_byte = '0;
    i_txDone = 1'b0;
    forever begin
      @(negedge clk);
      i_txDone = 1'b0;
      if (cyc == force_done_cyc) i_txDone = 1'b1;
      if (o_tx_start === 1'b1) begin
        check("no_overlap", 32'(inflight), 0);
        inflight   = 1'b1;
        cnt        = done_delay;
        start_byte = o_data;
      end else if (inflight && !hold_done) begin
        if (cnt > 1) cnt--;
        else begin
          check("data_held", o_data, start_byte);
          i_txDone      = 1'b1;
          inflight      = 1'b0;
          last_done_cyc = cyc;
        end
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    int k;
    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_result = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", o_tx_start, 0);
    check("rst_data",     o_data, 0);
    check("rst_busy",     o_busy, 0);
    check("rst_full",     o_full, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_state",    o_dbg_state, ST_IDLE);
    i_rst = 1'b0;
    @(negedge clk);

    // 1: single result, done 10 cycles after each start
    done_delay = 10;
    i_valid = 1'b1; i_result = 8'h2A; push_frame(8'h2A);
    @(negedge clk);
    i_valid = 1'b0;
    check("t1_no_early_start", o_tx_start, 0);
    @(negedge clk);
    check("t1_start_latency", o_tx_start, 1);
    check("t1_first_byte", o_data, M_HDR);
    wait_idle("t1", 1'b1);

    // 2: three results on consecutive cycles
    done_delay = 3;
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    wait_idle("t2", 1'b0);

    // 3: UART stalled, six results: one in flight, four queued, one dropped
    hold_done  = 1'b1;
    done_delay = 2;
    for (int i = 0; i < 6; i++) send(8'h40 + 8'(i), i < 5);
    repeat (2) @(negedge clk);
    check("t3_full",     o_full, 1);
    check("t3_overflow", o_overflow, 1);
    check("t3_busy",     o_busy, 1);
    check("t3_state",    o_dbg_state, ST_WAIT_HDR);
    hold_done = 1'b0;
    wait_idle("t3", 1'b0);
    check("t3_overflow_sticky", o_overflow, 1);

    // 4: spurious i_txDone in IDLE and during the HDR cycle
    force_done_cyc = cyc + 1;
    repeat (3) @(negedge clk);
    check("t4_idle_state", o_dbg_state, ST_IDLE);
    check("t4_idle_busy",  o_busy, 0);
    done_delay = 4;
    i_valid = 1'b1; i_result = 8'h55; push_frame(8'h55);
    @(negedge clk);
    i_valid = 1'b0;
    force_done_cyc = cyc + 1;
    @(negedge clk);
    check("t4_in_hdr", o_dbg_state, ST_HDR);
    @(negedge clk);
    check("t4_hdr_done_ignored", o_dbg_state, ST_WAIT_HDR);
    check("t4_no_second_start",  o_tx_start, 0);
    wait_idle("t4", 1'b0);

    // 5: reset during WAIT_DAT with two results queued
    done_delay = 6;
    send(8'h61, 1'b1);
    send(8'h62, 1'b1);
    send(8'h63, 1'b1);
    k = 0;
    while (o_dbg_state !== ST_WAIT_DAT && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t5_reached_wait_dat", 32'(k < 200), 1);
    i_rst    = 1'b1;
    inflight = 1'b0;
    exp_q.delete();
    pending  = 0;
    @(negedge clk);
    i_rst    = 1'b0;
    byte_idx = 0;
    check("t5_tx_start", o_tx_start, 0);
    check("t5_data",     o_data, 0);
    check("t5_busy",     o_busy, 0);
    check("t5_full",     o_full, 0);
    check("t5_overflow", o_overflow, 0);
    check("t5_state",    o_dbg_state, ST_IDLE);
    repeat (4) @(negedge clk);
    send(8'h10, 1'b1);
    wait_idle("t5", 1'b0);

    // 6a: result equal to the header gives a zero checksum
    send(8'h04, 1'b1);
    wait_idle("t6a", 1'b0);

    // 6b: write into a full queue in the same cycle as a pop
    hold_done  = 1'b1;
    done_delay = 2;
    for (int i = 0; i < 5; i++) send(8'h71 + 8'(i), 1'b1);
    repeat (2) @(negedge clk);
    check("t6_full_before", o_full, 1);
    hold_done = 1'b0;
    k = 0;
    while (!(o_dbg_state === ST_IDLE && o_full === 1'b1) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("t6_idle_with_full", 32'(k < 500), 1);
    i_valid = 1'b1; i_result = 8'h7E; push_frame(8'h7E);
    @(negedge clk);
    i_valid = 1'b0;
    check("t6_full_kept", o_full, 1);
    check("t6_no_overflow", o_overflow, 0);
    wait_idle("t6b", 1'b0);
    check("t6_no_overflow_end", o_overflow, 0);

    // Randomised traffic, never offering more than the queue can take
    for (int n = 0; n < 30; n++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      done_delay = $urandom_range(1, 6);
      repeat ($urandom_range(0, 8)) @(negedge clk);
      k = 0;
      while (pending >= 4 && k < 500) begin
        @(negedge clk);
        k++;
      end
      send(r, 1'b1);
    end
    wait_idle("rand", 1'b0);
    check("rand_no_overflow", o_overflow, 0);
    check("final_exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
